// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - LSU shared bus width, func encodings, FSM states and helpers
package lsu_pkg;

  localparam int CPU_BUS = 32;

  // Load encodings; stores reuse the low codes (SB=LB, SH=LH, SW=LW)
  localparam logic [2:0] FUNC_LB  = 3'b000;
  localparam logic [2:0] FUNC_LH  = 3'b001;
  localparam logic [2:0] FUNC_LW  = 3'b010;
  localparam logic [2:0] FUNC_LBU = 3'b100;
  localparam logic [2:0] FUNC_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // func[1:0] carries the access width: 00 byte, 01 half, 10 word
  function automatic logic is_misaligned(input logic [2:0] func, input logic [1:0] lane);
    case (func[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - LSU memory request/response bus with LSU and memory side views
interface lsu_if;
  import lsu_pkg::*;

  logic               o_mem_req;
  logic               o_mem_we;
  logic [CPU_BUS-1:0] o_mem_addr;
  logic [CPU_BUS-1:0] o_mem_wdata;
  logic [3:0]         o_mem_wmask;
  logic               i_mem_gnt;
  logic               i_mem_rvalid;
  logic [CPU_BUS-1:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - LSU byte-lane logic: store mask/replication, load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]         func,
  input  logic [1:0]         lane,
  input  logic [CPU_BUS-1:0] wdata,
  input  logic [CPU_BUS-1:0] rdata,
  output logic [3:0]         wmask,
  output logic [CPU_BUS-1:0] wdata_lane,
  output logic [CPU_BUS-1:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Store data is replicated across the word so every lane carries it; the mask picks the lane
  always_comb begin
    wmask      = 4'b1111;
    wdata_lane = wdata;
    case (func[1:0])
      2'b00: begin
        wmask      = 4'b0001 << lane;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        wmask      = 4'b0011 << lane;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Select the addressed byte and halfword out of the returned word
  always_comb begin
    rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lane)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
  end

  // Sign or zero extend to the full bus; words pass through untouched
  always_comb begin
    rdata_ext = rdata;
    case (func)
      FUNC_LB:  rdata_ext = {{24{rbyte[7]}}, rbyte};
      FUNC_LH:  rdata_ext = {{16{rhalf[15]}}, rhalf};
      FUNC_LBU: rdata_ext = {24'b0, rbyte};
      FUNC_LHU: rdata_ext = {16'b0, rhalf};
      default:  ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - LSU top: EXU/WBU handshakes, memory FSM, result register (optional LSU_MISALIGN_CHECK_EN)
module lsu
  import lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_pre_valid,
  output logic               o_pre_ready,
  input  logic               i_lsu_ren,
  input  logic               i_lsu_wen,
  input  logic [2:0]         i_lsu_func,
  input  logic [CPU_BUS-1:0] i_lsu_addr,
  input  logic [CPU_BUS-1:0] i_lsu_wdata,
  input  logic [CPU_BUS-1:0] i_lsu_alu_res,
  output logic               o_post_valid,
  input  logic               i_post_ready,
  output logic [CPU_BUS-1:0] o_lsu_rd,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic               o_lsu_misalign,
`endif
  lsu_if.master              mem
);

  lsu_state_t state, state_nxt;

  logic [CPU_BUS-1:0] addr_q, wdata_q, alu_q, rd_q;
  logic [2:0]         func_q;
  logic               ren_q, wen_q;
  logic               accept, resp_done, misal_now;
  logic [3:0]         wmask_lane;
  logic [CPU_BUS-1:0] wdata_lane, rdata_ext;

  assign accept    = (state == ST_IDLE) && i_pre_valid;
  assign resp_done = mem.i_mem_rvalid &&
                     ((state == ST_WAIT) || ((state == ST_REQ) && mem.i_mem_gnt));

`ifdef LSU_MISALIGN_CHECK_EN
  logic misal_q;
  assign misal_now      = (i_lsu_ren || i_lsu_wen) && is_misaligned(i_lsu_func, i_lsu_addr[1:0]);
  assign o_lsu_misalign = misal_q && (state == ST_DONE);

  // Misalign flag lives from acceptance until the result is handed to WBU
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         misal_q <= 1'b0;
    else if (accept)                                 misal_q <= misal_now;
    else if ((state == ST_DONE) && i_post_ready)     misal_q <= 1'b0;
  end
`else
  assign misal_now = 1'b0;
`endif

  lsu_align u_align (
    .func       (func_q),
    .lane       (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem.i_mem_rdata),
    .wmask      (wmask_lane),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  // State register; reset drops any in-flight request so a late response lands in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: ALU-only and rejected misaligned ops bypass memory straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_pre_valid)
                 state_nxt = ((i_lsu_ren || i_lsu_wen) && !misal_now) ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem.i_mem_gnt)
                 state_nxt = mem.i_mem_rvalid ? ST_DONE : ST_WAIT;
      ST_WAIT: if (mem.i_mem_rvalid) state_nxt = ST_DONE;
      ST_DONE: if (i_post_ready)     state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture on accept; result is the ALU value unless a load response replaces it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      func_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= i_lsu_addr;
      wdata_q <= i_lsu_wdata;
      alu_q   <= i_lsu_alu_res;
      func_q  <= i_lsu_func;
      ren_q   <= i_lsu_ren;
      wen_q   <= i_lsu_wen;
      rd_q    <= misal_now ? '0 : i_lsu_alu_res;
    end else if (resp_done) begin
      rd_q    <= (ren_q && !wen_q) ? rdata_ext : alu_q;
    end
  end

  // Outputs decode from state only, so memory fields are stable for the whole REQ phase
  always_comb begin
    o_pre_ready     = (state == ST_IDLE);
    o_post_valid    = (state == ST_DONE);
    o_lsu_rd        = rd_q;
    mem.o_mem_req   = 1'b0;
    mem.o_mem_we    = 1'b0;
    mem.o_mem_addr  = '0;
    mem.o_mem_wdata = '0;
    mem.o_mem_wmask = 4'b0000;
    if (state == ST_REQ) begin
      mem.o_mem_req   = 1'b1;
      mem.o_mem_we    = wen_q;
      mem.o_mem_addr  = {addr_q[CPU_BUS-1:2], 2'b00};
      mem.o_mem_wdata = wdata_lane;
      mem.o_mem_wmask = wen_q ? wmask_lane : 4'b0000;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu (honours LSU_MISALIGN_CHECK_EN)
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pre_valid, o_pre_ready;
  logic        i_lsu_ren, i_lsu_wen;
  logic [2:0]  i_lsu_func;
  logic [31:0] i_lsu_addr, i_lsu_wdata, i_lsu_alu_res;
  logic        o_post_valid, i_post_ready;
  logic [31:0] o_lsu_rd;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        o_lsu_misalign;
`endif

  lsu_if mem_bus();

  always #5 clk = ~clk;

  lsu dut (
    .clk           (clk),
    .rst           (rst),
    .i_pre_valid   (i_pre_valid),
    .o_pre_ready   (o_pre_ready),
    .i_lsu_ren     (i_lsu_ren),
    .i_lsu_wen     (i_lsu_wen),
    .i_lsu_func    (i_lsu_func),
    .i_lsu_addr    (i_lsu_addr),
    .i_lsu_wdata   (i_lsu_wdata),
    .i_lsu_alu_res (i_lsu_alu_res),
    .o_post_valid  (o_post_valid),
    .i_post_ready  (i_post_ready),
    .o_lsu_rd      (o_lsu_rd),
`ifdef LSU_MISALIGN_CHECK_EN
    .o_lsu_misalign(o_lsu_misalign),
`endif
    .mem           (mem_bus.master)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic        chk_en = 1'b0;
  logic [31:0] exp_rd, exp_addr, exp_wdata;
  logic [3:0]  exp_wmask;
  logic        exp_mem, exp_we;
  logic [31:0] last_addr, last_wdata, op_rd;
  logic [3:0]  last_wmask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic m_misal(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (a[1:0] * 8)) & 32'hFF;
    h = (d >> (a[1] * 16)) & 32'hFFFF;
    case (f)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic ren, input logic wen, input logic [2:0] f,
                                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] alu);
    if ((ren || wen) && m_misal(f, a)) return 32'h0;
    if (wen || !ren) return alu;
    return m_load(f, a, d);
  endfunction

  function automatic logic [3:0] m_wmask(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] m;
    case (f[1:0])
      2'b00:   m = 32'd1 << a[1:0];
      2'b01:   m = 32'd3 << a[1:0];
      default: m = 32'd15;
    endcase
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] w);
    case (f[1:0])
      2'b00:   return (w & 32'hFF) * 32'h01010101;
      2'b01:   return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (o_post_valid) check("rd_vs_model", o_lsu_rd, exp_rd);
      if (mem_bus.o_mem_req) begin
        check("req_allowed", {31'b0, exp_mem}, 32'd1);
        check("mem_addr", mem_bus.o_mem_addr, exp_addr);
        check("mem_we", {31'b0, mem_bus.o_mem_we}, {31'b0, exp_we});
        check("mem_wdata", mem_bus.o_mem_wdata, exp_wdata);
        check("mem_wmask", {28'b0, mem_bus.o_mem_wmask}, {28'b0, exp_wmask});
        last_addr  = mem_bus.o_mem_addr;
        last_wdata = mem_bus.o_mem_wdata;
        last_wmask = mem_bus.o_mem_wmask;
      end
    end
  end

  task automatic set_exp(input logic ren, input logic wen, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] alu, input logic [31:0] d);
    exp_rd    = m_rd(ren, wen, f, a, d, alu);
    exp_mem   = (ren || wen) && !m_misal(f, a);
    exp_we    = wen;
    exp_addr  = a & 32'hFFFFFFFC;
    exp_wdata = m_wdata(f, w);
    exp_wmask = wen ? m_wmask(f, a) : 4'b0000;
  endtask

  // Present one op at a negedge; returns at the negedge after acceptance
  task automatic start_op(input logic ren, input logic wen, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] alu, input logic [31:0] d);
    @(negedge clk);
    set_exp(ren, wen, f, a, w, alu, d);
    check("pre_ready_idle", {31'b0, o_pre_ready}, 32'd1);
    i_lsu_ren = ren; i_lsu_wen = wen; i_lsu_func = f;
    i_lsu_addr = a; i_lsu_wdata = w; i_lsu_alu_res = alu;
    i_pre_valid = 1'b1;
    @(negedge clk);
    i_pre_valid = 1'b0;
    i_lsu_ren = 1'($urandom); i_lsu_wen = 1'($urandom); i_lsu_func = 3'($urandom);
    i_lsu_addr = $urandom; i_lsu_wdata = $urandom; i_lsu_alu_res = $urandom;
  endtask

  task automatic do_op(input logic ren, input logic wen, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] alu, input logic [31:0] d,
                       input int gnt_dly, input int rv_dly, input int post_dly);
    int t;
    start_op(ren, wen, f, a, w, alu, d);
    if (exp_mem) begin
      check("req_start", {31'b0, mem_bus.o_mem_req}, 32'd1);
      for (int k = 0; k < gnt_dly; k++) begin
        @(negedge clk);
        check("req_held", {31'b0, mem_bus.o_mem_req}, 32'd1);
      end
      mem_bus.i_mem_gnt    = 1'b1;
      mem_bus.i_mem_rvalid = (rv_dly == 0);
      mem_bus.i_mem_rdata  = (rv_dly == 0) ? d : $urandom;
      @(negedge clk);
      mem_bus.i_mem_gnt    = 1'b0;
      mem_bus.i_mem_rvalid = 1'b0;
      check("req_drop", {31'b0, mem_bus.o_mem_req}, 32'd0);
      if (rv_dly > 0) begin
        for (int k = 1; k < rv_dly; k++) @(negedge clk);
        mem_bus.i_mem_rvalid = 1'b1;
        mem_bus.i_mem_rdata  = d;
        @(negedge clk);
        mem_bus.i_mem_rvalid = 1'b0;
        mem_bus.i_mem_rdata  = $urandom;
      end
    end else begin
      check("post_valid_1cycle", {31'b0, o_post_valid}, 32'd1);
      check("no_mem_req", {31'b0, mem_bus.o_mem_req}, 32'd0);
    end
    t = 0;
    while (!o_post_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("post_valid_seen", {31'b0, o_post_valid}, 32'd1);
    op_rd = o_lsu_rd;
`ifdef LSU_MISALIGN_CHECK_EN
    check("misalign_flag", {31'b0, o_lsu_misalign}, {31'b0, (ren || wen) && m_misal(f, a)});
`endif
    for (int k = 0; k < post_dly; k++) begin
      check("hold_pre_ready", {31'b0, o_pre_ready}, 32'd0);
      check("hold_post_valid", {31'b0, o_post_valid}, 32'd1);
      check("hold_rd", o_lsu_rd, op_rd);
      @(negedge clk);
    end
    i_post_ready = 1'b1;
    @(negedge clk);
    i_post_ready = 1'b0;
    check("post_valid_fall", {31'b0, o_post_valid}, 32'd0);
    check("pre_ready_back", {31'b0, o_pre_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_pre_valid = 0; i_lsu_ren = 0; i_lsu_wen = 0; i_lsu_func = 0;
    i_lsu_addr = 0; i_lsu_wdata = 0; i_lsu_alu_res = 0; i_post_ready = 0;
    mem_bus.i_mem_gnt = 0; mem_bus.i_mem_rvalid = 0; mem_bus.i_mem_rdata = 0;
    exp_rd = 0; exp_addr = 0; exp_wdata = 0; exp_wmask = 0; exp_mem = 0; exp_we = 0;
    last_addr = 0; last_wdata = 0; last_wmask = 0; op_rd = 0;

    repeat (2) @(negedge clk);
    check("rst_post_valid", {31'b0, o_post_valid}, 32'd0);
    check("rst_mem_req", {31'b0, mem_bus.o_mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_bus.o_mem_we}, 32'd0);
    check("rst_mem_wmask", {28'b0, mem_bus.o_mem_wmask}, 32'd0);
    check("rst_mem_addr", mem_bus.o_mem_addr, 32'd0);
    check("rst_mem_wdata", mem_bus.o_mem_wdata, 32'd0);
    check("rst_lsu_rd", o_lsu_rd, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pre_ready", {31'b0, o_pre_ready}, 32'd1);
    chk_en = 1'b1;

    // Model pins
    check("model_lb", m_rd(1, 0, 3'b000, 32'h80000003, 32'h80FF0000, 0), 32'hFFFFFF80);
    check("model_lbu", m_rd(1, 0, 3'b100, 32'h80000003, 32'h80FF0000, 0), 32'h00000080);
    check("model_sh_mask", {28'b0, m_wmask(3'b001, 32'h80000002)}, 32'h0000000C);

    // ALU pass-through
    do_op(0, 0, 3'b000, 32'h0, 32'h0, 32'h1234, 32'h0, 0, 0, 0);
    check("alu_rd_lit", op_rd, 32'h00001234);
    // LB / LBU with gnt after 2 cycles, rvalid 3 later
    do_op(1, 0, 3'b000, 32'h80000003, 32'h0, 32'h55, 32'h80FF0000, 2, 3, 0);
    check("lb_rd_lit", op_rd, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h80000003, 32'h0, 32'h55, 32'h80FF0000, 2, 3, 0);
    check("lbu_rd_lit", op_rd, 32'h00000080);
    // SH lane replication
    do_op(0, 1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h77, 32'hDEAD0000, 2, 1, 0);
    check("sh_wmask_lit", {28'b0, last_wmask}, 32'h0000000C);
    check("sh_wdata_lit", last_wdata, 32'hABCDABCD);
    check("sh_addr_lit", last_addr, 32'h80000000);
    check("sh_rd_lit", op_rd, 32'h00000077);
    // LH with gnt and rvalid together
    do_op(1, 0, 3'b001, 32'h80000002, 32'h0, 32'h0, 32'h80011234, 0, 0, 0);
    check("lh_rd_lit", op_rd, 32'hFFFF8001);
    do_op(1, 0, 3'b101, 32'h80000000, 32'h0, 32'h0, 32'h0000F00D, 1, 1, 0);
    check("lhu_rd_lit", op_rd, 32'h0000F00D);
    // LW with WBU stalling 5 cycles
    do_op(1, 0, 3'b010, 32'h80000004, 32'h0, 32'h0, 32'hDEADBEEF, 0, 2, 5);
    check("lw_rd_lit", op_rd, 32'hDEADBEEF);
    // SB and ren+wen store
    do_op(0, 1, 3'b000, 32'h80000001, 32'h0000005A, 32'h99, 32'h12345678, 1, 2, 1);
    check("sb_wmask_lit", {28'b0, last_wmask}, 32'h00000002);
    check("sb_wdata_lit", last_wdata, 32'h5A5A5A5A);
    do_op(1, 1, 3'b010, 32'h80000008, 32'h12345678, 32'h42, 32'hFFFFFFFF, 0, 1, 0);
    check("rw_store_rd_lit", op_rd, 32'h00000042);
    // Misaligned word access
    do_op(1, 0, 3'b010, 32'h80000002, 32'h0, 32'h0, 32'hCAFEF00D, 1, 1, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("misal_rd_lit", op_rd, 32'h00000000);
`else
    check("misal_rd_lit", op_rd, 32'hCAFEF00D);
`endif

    // Reset mid-REQ
    start_op(1, 0, 3'b010, 32'h80000010, 32'h0, 32'h0, 32'h0);
    check("midreq_req", {31'b0, mem_bus.o_mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("midreq_rst_req", {31'b0, mem_bus.o_mem_req}, 32'd0);
    check("midreq_rst_addr", mem_bus.o_mem_addr, 32'd0);
    check("midreq_rst_valid", {31'b0, o_post_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-WAIT, then a stray response
    start_op(1, 0, 3'b010, 32'h80000014, 32'h0, 32'h0, 32'h0);
    mem_bus.i_mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.i_mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("midwait_rst_req", {31'b0, mem_bus.o_mem_req}, 32'd0);
    check("midwait_rst_valid", {31'b0, o_post_valid}, 32'd0);
    check("midwait_rst_rd", o_lsu_rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_bus.i_mem_rvalid = 1'b1;
    mem_bus.i_mem_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    mem_bus.i_mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stray_post_valid", {31'b0, o_post_valid}, 32'd0);
      check("stray_pre_ready", {31'b0, o_pre_ready}, 32'd1);
      check("stray_rd", o_lsu_rd, 32'd0);
      @(negedge clk);
    end

    // Normal operation after recovery
    do_op(0, 0, 3'b000, 32'h0, 32'h0, 32'h600DF00D, 32'h0, 0, 0, 0);
    check("recover_rd_lit", op_rd, 32'h600DF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
